// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// divide corner-case constants and op classification helpers.
// Optional feature macro: MD_MADD_EN (multiply-accumulate ops 6-9).
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  // Divide by zero: quotient all ones, remainder is the dividend.
  localparam logic [31:0] DIV0_QUOT        = 32'hFFFF_FFFF;
  // Signed overflow case: most-negative / -1.
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] DIV_OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_QUOT     = 32'h8000_0000;
  localparam logic [31:0] DIV_OVF_REM      = 32'h0000_0000;

  // Ops that run through the multi-cycle BUSY state.
  function automatic logic is_calc_op(input logic [3:0] code);
    case (code)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_calc_op = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_calc_op = 1'b1;
`endif
      default: is_calc_op = 1'b0;
    endcase
  endfunction

  // Ops that use the multiply latency rather than the divide latency.
  function automatic logic is_mul_op(input logic [3:0] code);
    case (code)
      MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_mul_op = 1'b1;
      default: is_mul_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for the multiply/divide unit.
// Result layout is {hi, lo}. Accumulate ops exist only with MD_MADD_EN.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] sq;
  logic [31:0] sr;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // A zero divisor is replaced by one so the dividers never see zero;
  // the zero case is overridden in the result mux anyway.
  assign div_b = (src_b == 32'd0) ? 32'd1 : src_b;
  assign uq    = src_a / div_b;
  assign ur    = src_a % div_b;

  // Signed divide on magnitudes, then restore signs: the quotient is
  // negative when signs differ, the remainder follows the dividend.
  assign abs_a  = src_a[31] ? (~src_a + 32'd1) : src_a;
  assign abs_b  = src_b[31] ? (~src_b + 32'd1) : div_b;
  assign sq_mag = abs_a / abs_b;
  assign sr_mag = abs_a % abs_b;
  assign sq     = (src_a[31] ^ src_b[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr     = src_a[31] ? (~sr_mag + 32'd1) : sr_mag;

`ifndef MD_MADD_EN
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  // Select the 64-bit result for the requested op.
  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        if (src_b == 32'd0)
          result = {src_a, DIV0_QUOT};
        else if (src_a == DIV_OVF_DIVIDEND && src_b == DIV_OVF_DIVISOR)
          result = {DIV_OVF_REM, DIV_OVF_QUOT};
        else
          result = {sr, sq};
      end
      MD_DIVU: begin
        if (src_b == 32'd0)
          result = {src_a, DIV0_QUOT};
        else
          result = {ur, uq};
      end
`ifdef MD_MADD_EN
      MD_MADD:  result = {hi, lo} + prod_s;
      MD_MADDU: result = {hi, lo} + prod_u;
      MD_MSUB:  result = {hi, lo} - prod_s;
      MD_MSUBU: result = {hi, lo} - prod_u;
`endif
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: IDLE/BUSY FSM, latency counter, pending result and
// HI/LO registers. Arithmetic lives in md_calc.
// Optional feature macro: MD_MADD_EN (MADD/MADDU/MSUB/MSUBU, ops 6-9).
// Handshake: start is sampled only in IDLE; while busy=1 any start is
// dropped (the hazard unit stalls instead). cancel aborts without writing.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state;
  logic [CNT_W-1:0] count;
  logic [63:0]      pending;
  logic [63:0]      result;

  md_calc u_calc (
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  // FSM, counter, pending result and HI/LO updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      count   <= '0;
      pending <= 64'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !cancel) begin
            if (is_calc_op(op)) begin
              pending <= result;
              count   <= is_mul_op(op) ? MUL_LOAD : DIV_LOAD;
              state   <= ST_BUSY;
              busy    <= 1'b1;
            end else if (op == MD_MTHI) begin
              hi <= src_a;
            end else if (op == MD_MTLO) begin
              lo <= src_a;
            end
          end
        end
        ST_BUSY: begin
          if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else if (count == '0) begin
            hi    <= pending[63:32];
            lo    <= pending[31:0];
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit (default parameters 5/10).
module tb_md_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    logic [63:0] ps, pu, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    pu = {32'd0, a} * {32'd0, b};
    res = 64'd0;
    case (o)
      4'd0: res = ps;
      4'd1: res = pu;
      4'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      4'd6: res = acc + ps;
      4'd7: res = acc + pu;
      4'd8: res = acc - ps;
      4'd9: res = acc - pu;
      default: res = acc;
    endcase
    return res;
  endfunction

  function automatic int latency(input logic [3:0] o);
    return (o == 4'd2 || o == 4'd3) ? DIV_N : MUL_N;
  endfunction

  // Issue one compute op, count busy cycles, then check hi/lo.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [63:0] r;
    int cnt;
    bit early;
    r = ref_result(o, a, b, {exp_hi, exp_lo});
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); src_a = $urandom; src_b = $urandom;
    cnt = 0; early = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (hi !== exp_hi || lo !== exp_lo) early = 1;
      @(negedge clk);
    end
    checks++;
    if (cnt != latency(o)) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, latency(o));
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL %s hilo_changed_while_busy", name);
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    checks++;
    if (hi !== exp_hi) begin
      errors++;
      $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi);
    end
    checks++;
    if (lo !== exp_lo) begin
      errors++;
      $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo);
    end
  endtask

  // Single MTHI/MTLO write with a check one edge later.
  task automatic move_to(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; op = o; src_a = v; src_b = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (o == 4'd4) exp_hi = v; else exp_lo = v;
    checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL move_to op%0d: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
               o, busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++;
    if (hi !== 32'd0) begin errors++; $display("FAIL reset hi: got %h expected 0", hi); end
    checks++;
    if (lo !== 32'd0) begin errors++; $display("FAIL reset lo: got %h expected 0", lo); end
  endtask

  task automatic test_mult;
    run_op(4'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(4'd0, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
    for (int i = 0; i < 8; i++)
      run_op(4'($urandom_range(0, 1)), $urandom, $urandom, "mult_rand");
  endtask

  task automatic test_div;
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    run_op(4'd3, 32'd7, 32'd0, "divu_by0");
    run_op(4'd2, 32'hFFFF_FFF9, 32'd0, "div_by0");
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(4'd2, 32'd7, 32'hFFFF_FFFE, "div_7byneg2");
    for (int i = 0; i < 8; i++)
      run_op(4'($urandom_range(2, 3)), $urandom,
             ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)), "div_rand");
  endtask

  task automatic test_back_to_back_moves;
    @(negedge clk);
    start = 1'b1; op = 4'd4; src_a = 32'h1234_5678;
    @(negedge clk);
    exp_hi = 32'h1234_5678;
    checks++;
    if (busy !== 1'b0 || hi !== exp_hi) begin
      errors++;
      $display("FAIL mthi: busy=%b hi=%h expected busy=0 hi=%h", busy, hi, exp_hi);
    end
    op = 4'd5; src_a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    exp_lo = 32'h9ABC_DEF0;
    checks++;
    if (busy !== 1'b0 || lo !== exp_lo || hi !== exp_hi) begin
      errors++;
      $display("FAIL mtlo: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
               busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  // Start an op, assert cancel during busy cycle k; result must never land.
  task automatic cancel_at(input int k, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input string name);
    bit bad;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int c = 1; c < k; c++) begin
      if (busy !== 1'b1) bad = 1;
      @(negedge clk);
    end
    if (busy !== 1'b1) bad = 1;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (bad || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_cancel: got %b (pre-cancel ok=%0d) expected 0", name, busy, !bad);
    end
    repeat (DIV_N + 2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL %s hilo_after_cancel: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
               name, busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_cancel;
    cancel_at(4, 4'd3, 32'd100, 32'd7, "cancel_divu_c4");
    cancel_at(DIV_N, 4'd2, $urandom, 32'd9, "cancel_div_last");
    cancel_at(1, 4'd0, $urandom, $urandom, "cancel_mult_c1");
    cancel_at(MUL_N, 4'd1, $urandom, $urandom, "cancel_multu_last");
    // cancel in IDLE suppresses same-cycle starts
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 4'd4; src_a = ~exp_hi;
    @(negedge clk);
    op = 4'd0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL idle_cancel: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
               busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  // A start during busy is dropped; the in-flight DIVU still completes.
  task automatic test_start_while_busy;
    int cnt;
    @(negedge clk);
    start = 1'b1; op = 4'd3; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 2) begin start = 1'b1; op = 4'd0; src_a = $urandom; src_b = $urandom; end
      else if (cnt == 3) begin start = 1'b0; end
      @(negedge clk);
    end
    start = 1'b0;
    exp_hi = 32'd2; exp_lo = 32'd14;
    checks++;
    if (cnt != DIV_N) begin
      errors++;
      $display("FAIL ignore_start busy_cycles: got %0d expected %0d", cnt, DIV_N);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL ignore_start hilo: hi=%h lo=%h expected hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
    end
    repeat (MUL_N + 2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL ignore_start late: busy=%b hi=%h lo=%h", busy, hi, lo);
    end
  endtask

  task automatic test_reserved;
    int first;
`ifdef MD_MADD_EN
    first = 10;
`else
    first = 6;
`endif
    for (int c = first; c < 16; c++) begin
      @(negedge clk);
      start = 1'b1; op = 4'(c); src_a = $urandom; src_b = $urandom;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        errors++;
        $display("FAIL reserved op%0d: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                 c, busy, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

`ifdef MD_MADD_EN
  task automatic test_madd;
    move_to(4'd4, 32'd0);
    move_to(4'd5, 32'hFFFF_FFFF);
    run_op(4'd7, 32'd1, 32'd1, "maddu_carry");
    for (int i = 0; i < 8; i++)
      run_op(4'($urandom_range(6, 9)), $urandom, $urandom, "madd_rand");
  endtask
`endif

  task automatic test_reset_mid_op;
    @(negedge clk);
    start = 1'b1; op = 4'd2; src_a = $urandom; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected all 0", busy, hi, lo);
    end
    repeat (DIV_N + 2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid late: busy=%b hi=%h lo=%h expected all 0", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back_moves();
    test_cancel();
    test_start_while_busy();
    move_to(4'd4, $urandom);
    move_to(4'd5, $urandom);
    test_reserved();
`ifdef MD_MADD_EN
    test_madd();
`endif
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
